mem_req_ctrl: RTL

Load/store initiator that sits between the CPU datapath and `data_mem`. Accepts one load or store request at a time over a valid/ready handshake and forms the effective address as base + signed offset. It drives `data_mem`'s `rdMem`/`wrMem` strobes, absorbs the memory's one-cycle registered read latency, and returns the result over a valid/ready response channel. Out-of-range addresses are faulted without touching memory, and per-type access counters are kept.

---
 rtl/cpu_mem_defs.sv | 15 +
 rtl/sat_counter.sv | 19 +
 rtl/mem_req_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cpu_mem_defs.sv
// rtl/cpu_mem_defs.sv - shared CPU/data_mem constants and the load/store FSM encoding
package cpu_mem_defs;

  localparam int DATA_W        = 32;
  localparam int ADDR_BITS_DEF = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STORE = 3'd1,
    LOAD  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - single-outstanding load/store initiator in front of data_mem
module mem_req_ctrl
  import cpu_mem_defs::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_base,
  input  logic [DATA_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              resp_store,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrData,
  output logic              mem_rdMem,
  output logic              mem_wrMem,
  input  logic [DATA_W-1:0] mem_rdData,
  output logic [CNT_W-1:0]  ld_count,
  output logic [CNT_W-1:0]  st_count,
  output logic [CNT_W-1:0]  fault_count
);

  localparam logic [DATA_W-1:0] ADDR_MASK = (DATA_W'(1) << ADDR_BITS) - DATA_W'(1);

  state_t            state;
  logic [DATA_W-1:0] ea;
  logic [DATA_W-1:0] ea_addr;
  logic              ea_fault;
  logic              resp_hs;

  // Effective address wraps modulo 2^32; any bit above the memory index faults.
  assign ea       = req_base + req_offset;
  assign ea_addr  = ea & ADDR_MASK;
  assign ea_fault = (ea & ~ADDR_MASK) != '0;
  assign resp_hs  = resp_valid && resp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      resp_store <= 1'b0;
      mem_addr   <= '0;
      mem_wrData <= '0;
      mem_rdMem  <= 1'b0;
      mem_wrMem  <= 1'b0;
    end else begin
      mem_rdMem <= 1'b0;
      mem_wrMem <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            mem_addr   <= ea_addr;
            mem_wrData <= req_wdata;
            resp_rdata <= '0;
            resp_fault <= ea_fault;
            resp_store <= req_we;
            if (ea_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (req_we) begin
              state     <= STORE;
              mem_wrMem <= 1'b1;
            end else begin
              state     <= LOAD;
              mem_rdMem <= 1'b1;
            end
          end
        end
        STORE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        LOAD: begin
          state <= CAPT;
        end
        // data_mem's registered read data is valid only in this cycle
        CAPT: begin
          resp_rdata <= mem_rdData;
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_ld_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (resp_hs && !resp_fault && !resp_store),
    .count (ld_count)
  );

  sat_counter #(.W(CNT_W)) u_st_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (resp_hs && !resp_fault && resp_store),
    .count (st_count)
  );

  sat_counter #(.W(CNT_W)) u_flt_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (resp_hs && resp_fault),
    .count (fault_count)
  );

endmodule
